// File: rtl/led_matrix_pkg.sv
// Shared constants and helpers for the LED matrix PWM driver: pixel bit
// addressing, counter widths and the per-row lit decision.
package led_matrix_pkg;

    // LSB position of pixel (col,row) inside the chain / frame buffer.
    function automatic int pix_lsb(input int col, input int row, input int nrows, input int bpp);
        return (col * nrows + row) * bpp;
    endfunction

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A row is lit once blanking is over and the phase's top bits are below the pixel level.
    function automatic logic phase_lit(input logic [31:0] phase, input logic [31:0] blank_len,
                                       input int duty_shift, input logic [31:0] level);
        return (phase >= blank_len) && ((phase >> duty_shift) < level);
    endfunction

endpackage

// File: rtl/lmd_scan_timer.sv
// Scan sequencing: prescaler -> phase tick -> column advance, plus the
// frame-wrap strobe used for tear-free buffer swaps.
module lmd_scan_timer
    import led_matrix_pkg::*;
#(
    parameter int NCOLS   = 8,
    parameter int PHASE_W = 5,
    parameter int PRESC   = 90,
    parameter int COL_W   = cnt_width(NCOLS)
) (
    input  logic               dclk,
    input  logic               reset,
    output logic [PHASE_W-1:0] phase_o,
    output logic [COL_W-1:0]   col_o,
    output logic               frame_wrap_o
);

    localparam int PRESC_W = cnt_width(PRESC);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               tick_s;

    // Next-state for prescaler, phase and column counters.
    always_comb begin
        tick_s  = (presc_q == PRESC_W'(PRESC - 1));
        presc_d = tick_s ? {PRESC_W{1'b0}} : presc_q + PRESC_W'(1);
        phase_d = phase_q;
        col_d   = col_q;
        if (tick_s) begin
            phase_d = phase_q + PHASE_W'(1);
            if (phase_q == {PHASE_W{1'b1}}) begin
                col_d = (col_q == COL_W'(NCOLS - 1)) ? {COL_W{1'b0}} : col_q + COL_W'(1);
            end else begin
                col_d = col_q;
            end
        end else begin
            phase_d = phase_q;
        end
        frame_wrap_o = tick_s && (phase_q == {PHASE_W{1'b1}}) && (col_q == COL_W'(NCOLS - 1));
    end

    // Counter registers.
    always_ff @(posedge dclk) begin
        if (reset) begin
            presc_q <= {PRESC_W{1'b0}};
            phase_q <= {PHASE_W{1'b0}};
            col_q   <= {COL_W{1'b0}};
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
            col_q   <= col_d;
        end
    end

    assign phase_o = phase_q;
    assign col_o   = col_q;

endmodule

// File: rtl/led_matrix_pwm_driver.sv
// Multiplexed LED matrix driver: serial load chain, double-buffered frame,
// PWM row drive. Define LMD_SOUT_EN to add the daisy-chain output sout.
module led_matrix_pwm_driver
    import led_matrix_pkg::*;
#(
    parameter int NCOLS   = 8,
    parameter int NROWS   = 8,
    parameter int BPP     = 2,
    parameter int PHASE_W = 5,
    parameter int PRESC   = 90
) (
    input  logic               dclk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic               strobe,
    input  logic [PHASE_W-1:0] blank_len,
    output logic [NROWS-1:0]   row_out,
    output logic [NCOLS-1:0]   col_sel,
    output logic               frame_ack
`ifdef LMD_SOUT_EN
    ,
    output logic               sout
`endif
);

    localparam int CHAIN_W = NCOLS * NROWS * BPP;
    localparam int WORD_W  = NROWS * BPP;
    localparam int COL_W   = cnt_width(NCOLS);

    logic [CHAIN_W-1:0] chain_q, chain_d;
    logic [CHAIN_W-1:0] fbuf_q, fbuf_d;
    logic               pending_q, pending_d;
    logic [NROWS-1:0]   row_out_q, row_out_d;
    logic [NCOLS-1:0]   col_sel_q, col_sel_d;
    logic               frame_ack_q, frame_ack_d;

    logic [PHASE_W-1:0] phase_s;
    logic [COL_W-1:0]   col_s;
    logic               frame_wrap_s;
    logic               shift_s;
    logic               swap_s;
    logic               blanked_s;
    logic [WORD_W-1:0]  col_words_s [NCOLS];
    logic [WORD_W-1:0]  cur_word_s;
    logic [NROWS-1:0]   lit_s;

    lmd_scan_timer #(
        .NCOLS   (NCOLS),
        .PHASE_W (PHASE_W),
        .PRESC   (PRESC),
        .COL_W   (COL_W)
    ) u_scan (
        .dclk         (dclk),
        .reset        (reset),
        .phase_o      (phase_s),
        .col_o        (col_s),
        .frame_wrap_o (frame_wrap_s)
    );

    for (genvar c = 0; c < NCOLS; c++) begin : g_col
        assign col_words_s[c] = fbuf_q[pix_lsb(c, 0, NROWS, BPP) +: WORD_W];
    end

    assign cur_word_s = col_words_s[col_s];

    for (genvar r = 0; r < NROWS; r++) begin : g_row
        assign lit_s[r] = phase_lit(32'(phase_s), 32'(blank_len), PHASE_W - BPP,
                                    32'(cur_word_s[r*BPP +: BPP]));
    end

    // Load chain, pending handshake, buffer swap and output next-state.
    always_comb begin
        shift_s   = din_valid && !pending_q;
        swap_s    = frame_wrap_s && pending_q;
        blanked_s = (phase_s < blank_len);
        chain_d   = shift_s ? {chain_q[CHAIN_W-2:0], din} : chain_q;
        fbuf_d    = swap_s ? chain_q : fbuf_q;
        if (swap_s) begin
            pending_d = 1'b0;
        end else if (strobe) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
        frame_ack_d = swap_s;
        row_out_d   = lit_s;
        col_sel_d   = blanked_s ? {NCOLS{1'b0}} : (NCOLS'(1) << col_s);
    end

    // State and registered outputs.
    always_ff @(posedge dclk) begin
        if (reset) begin
            chain_q     <= {CHAIN_W{1'b0}};
            fbuf_q      <= {CHAIN_W{1'b0}};
            pending_q   <= 1'b0;
            row_out_q   <= {NROWS{1'b0}};
            col_sel_q   <= {NCOLS{1'b0}};
            frame_ack_q <= 1'b0;
        end else begin
            chain_q     <= chain_d;
            fbuf_q      <= fbuf_d;
            pending_q   <= pending_d;
            row_out_q   <= row_out_d;
            col_sel_q   <= col_sel_d;
            frame_ack_q <= frame_ack_d;
        end
    end

    assign din_ready = !pending_q;
    assign row_out   = row_out_q;
    assign col_sel   = col_sel_q;
    assign frame_ack = frame_ack_q;
`ifdef LMD_SOUT_EN
    assign sout      = chain_q[CHAIN_W-1];
`endif

endmodule

// File: tb/tb_led_matrix_pwm_driver.sv
// Self-checking bench for led_matrix_pwm_driver: random images checked against
// an arithmetic scan/PWM model; a second PRESC=90 instance checks column timing.
module tb_led_matrix_pwm_driver;

    localparam int NC    = 8;
    localparam int NR    = 8;
    localparam int BPP   = 2;
    localparam int PW    = 5;
    localparam int NPH   = 32;
    localparam int P     = 1;
    localparam int FRAME = NPH * NC * P;

    logic          dclk = 1'b0;
    logic          reset = 1'b1;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic          strobe = 1'b0;
    logic [PW-1:0] blank_len = '0;
    logic          din_ready;
    logic [NR-1:0] row_out;
    logic [NC-1:0] col_sel;
    logic          frame_ack;

    logic          s_din = 1'b0;
    logic          s_din_valid = 1'b0;
    logic          s_strobe = 1'b0;
    logic [PW-1:0] s_blank = '0;
    logic          s_din_ready;
    logic [NR-1:0] s_row_out;
    logic [NC-1:0] s_col_sel;
    logic          s_frame_ack;
`ifdef LMD_SOUT_EN
    logic          sout;
    logic          s_sout;
`endif

    int checks = 0;
    int fails  = 0;
    int n      = 0;
    int img [NC][NR];

    led_matrix_pwm_driver #(.NCOLS(NC), .NROWS(NR), .BPP(BPP), .PHASE_W(PW), .PRESC(P)) dut (
        .dclk(dclk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .strobe(strobe), .blank_len(blank_len), .row_out(row_out), .col_sel(col_sel),
        .frame_ack(frame_ack)
`ifdef LMD_SOUT_EN
        , .sout(sout)
`endif
    );

    led_matrix_pwm_driver #(.NCOLS(NC), .NROWS(NR), .BPP(BPP), .PHASE_W(PW), .PRESC(90)) dut_slow (
        .dclk(dclk), .reset(reset), .din(s_din), .din_valid(s_din_valid), .din_ready(s_din_ready),
        .strobe(s_strobe), .blank_len(s_blank), .row_out(s_row_out), .col_sel(s_col_sel),
        .frame_ack(s_frame_ack)
`ifdef LMD_SOUT_EN
        , .sout(s_sout)
`endif
    );

    always #5 dclk = ~dclk;

    // Edges since the last reset edge.
    always @(posedge dclk) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    // Expected rows for the scan state s cycles after reset.
    function automatic logic [NR-1:0] model_row(input int s, input int blank);
        int ph  = (s / P) % NPH;
        int col = (s / P / NPH) % NC;
        logic [NR-1:0] v = '0;
        for (int r = 0; r < NR; r++)
            v[r] = (ph >= blank) && ((ph * (1 << BPP)) / NPH < img[col][r]);
        return v;
    endfunction

    function automatic logic [NC-1:0] model_col(input int s, input int blank);
        int ph  = (s / P) % NPH;
        int col = (s / P / NPH) % NC;
        logic [NC-1:0] v = '0;
        if (ph >= blank) v[col] = 1'b1;
        return v;
    endfunction

    task automatic load_image();
        for (int j = NC * NR * BPP - 1; j >= 0; j--) begin
            int p = j / BPP;
            din       = ((img[p / NR][p % NR] >> (j % BPP)) & 1) != 0;
            din_valid = 1'b1;
            @(negedge dclk);
        end
        din_valid = 1'b0;
    endtask

    task automatic pulse_strobe();
        strobe = 1'b1;
        @(negedge dclk);
        strobe = 1'b0;
    endtask

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            @(negedge dclk);
            if (frame_ack) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge dclk);
        checks++; if (row_out !== 8'h00) begin fails++; $display("FAIL reset_row_out got %h want 00", row_out); end
        checks++; if (col_sel !== 8'h00) begin fails++; $display("FAIL reset_col_sel got %h want 00", col_sel); end
        checks++; if (frame_ack !== 1'b0) begin fails++; $display("FAIL reset_frame_ack got %b want 0", frame_ack); end
        checks++; if (din_ready !== 1'b1) begin fails++; $display("FAIL reset_din_ready got %b want 1", din_ready); end
        reset = 1'b0;
    endtask

    task automatic test_frames();
        bit got;
        int blank;
        for (int t = 0; t < 6; t++) begin
            for (int c = 0; c < NC; c++)
                for (int r = 0; r < NR; r++)
                    img[c][r] = (t == 0) ? 3 : (t == 1) ? 0 : int'($urandom_range(0, 3));
            if (t == 1) img[2][5] = 1;
            case (t)
                0:       blank = 4;
                1, 2:    blank = 0;
                3:       blank = 31;
                default: blank = int'($urandom_range(0, 31));
            endcase
            blank_len = PW'(blank);
            load_image();
            pulse_strobe();
            wait_ack(got);
            checks++; if (!got) begin fails++; $display("FAIL frames_ack t=%0d got none want pulse", t); end
            checks++; if (n % FRAME != 0) begin fails++; $display("FAIL frames_ack_align t=%0d got n=%0d want multiple of %0d", t, n, FRAME); end
            for (int k = 0; k < FRAME; k++) begin
                @(negedge dclk);
                checks++;
                if (row_out !== model_row(n - 1, blank) || col_sel !== model_col(n - 1, blank) || frame_ack !== 1'b0) begin
                    fails++;
                    if (fails < 20)
                        $display("FAIL frames t=%0d n=%0d row_out=%h want %h col_sel=%h want %h ack=%b want 0",
                                 t, n, row_out, model_row(n - 1, blank), col_sel, model_col(n - 1, blank), frame_ack);
                end
            end
        end
    endtask

    task automatic test_pending();
        bit got;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                img[c][r] = int'($urandom_range(0, 3));
        blank_len = 5'd2;
        load_image();
        for (int i = 0; i < FRAME + 2 && (n % FRAME) != 10; i++) @(negedge dclk);
        pulse_strobe();
        checks++; if (din_ready !== 1'b0) begin fails++; $display("FAIL pending_ready got %b want 0", din_ready); end
        for (int i = 0; i < 20; i++) begin
            din       = $urandom_range(0, 1) != 0;
            din_valid = 1'b1;
            strobe    = (i == 7);
            @(negedge dclk);
        end
        din_valid = 1'b0;
        strobe    = 1'b0;
        checks++; if (din_ready !== 1'b0) begin fails++; $display("FAIL pending_ready_hold got %b want 0", din_ready); end
        wait_ack(got);
        checks++; if (!got) begin fails++; $display("FAIL pending_ack got none want pulse"); end
        checks++; if (din_ready !== 1'b1) begin fails++; $display("FAIL pending_ready_after got %b want 1", din_ready); end
        for (int k = 0; k < FRAME; k++) begin
            @(negedge dclk);
            checks++;
            if (row_out !== model_row(n - 1, 2) || col_sel !== model_col(n - 1, 2) || frame_ack !== 1'b0) begin
                fails++;
                if (fails < 20)
                    $display("FAIL pending_frame n=%0d row_out=%h want %h col_sel=%h want %h ack=%b want 0",
                             n, row_out, model_row(n - 1, 2), col_sel, model_col(n - 1, 2), frame_ack);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        for (int i = 0; i < 50; i++) begin
            din       = $urandom_range(0, 1) != 0;
            din_valid = 1'b1;
            @(negedge dclk);
        end
        din_valid = 1'b0;
        pulse_strobe();
        din_valid = 1'b1;
        repeat (3) @(negedge dclk);
        reset = 1'b1;
        @(negedge dclk);
        checks++; if (row_out !== 8'h00) begin fails++; $display("FAIL midrst_row_out got %h want 00", row_out); end
        checks++; if (col_sel !== 8'h00) begin fails++; $display("FAIL midrst_col_sel got %h want 00", col_sel); end
        checks++; if (frame_ack !== 1'b0) begin fails++; $display("FAIL midrst_frame_ack got %b want 0", frame_ack); end
        checks++; if (din_ready !== 1'b1) begin fails++; $display("FAIL midrst_din_ready got %b want 1", din_ready); end
        reset     = 1'b0;
        din_valid = 1'b0;
        blank_len = 5'd0;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                img[c][r] = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge dclk);
            checks++;
            if (frame_ack !== 1'b0 || row_out !== model_row(n - 1, 0) || col_sel !== model_col(n - 1, 0)) begin
                fails++;
                if (fails < 20)
                    $display("FAIL midrst_idle n=%0d ack=%b want 0 row_out=%h want %h col_sel=%h want %h",
                             n, frame_ack, row_out, model_row(n - 1, 0), col_sel, model_col(n - 1, 0));
            end
        end
        pulse_strobe();
        wait_ack(got);
        checks++; if (!got) begin fails++; $display("FAIL midrst_ack got none want pulse"); end
        for (int k = 0; k < FRAME; k++) begin
            @(negedge dclk);
            checks++;
            if (row_out !== 8'h00) begin
                fails++;
                if (fails < 20) $display("FAIL midrst_chain_cleared n=%0d row_out=%h want 00", n, row_out);
            end
        end
    endtask

    task automatic test_period();
        logic [NC-1:0] prev, cur, want;
        int period, cnt;
        for (int inst = 0; inst < 2; inst++) begin
            period = (inst == 0) ? NPH * P : NPH * 90;
            blank_len = 5'd0;
            @(negedge dclk);
            prev = (inst == 0) ? col_sel : s_col_sel;
            cnt = 0;
            do begin
                @(negedge dclk);
                cur = (inst == 0) ? col_sel : s_col_sel;
                cnt++;
            end while (cur === prev && cnt < 2 * period + 10);
            checks++; if (cur === prev) begin fails++; $display("FAIL period_sync inst=%0d got no column change", inst); end
            prev = cur;
            for (int i = 0; i < 9; i++) begin
                cnt = 0;
                do begin
                    @(negedge dclk);
                    cur = (inst == 0) ? col_sel : s_col_sel;
                    cnt++;
                end while (cur === prev && cnt < 2 * period + 10);
                want = (prev == 8'h80) ? 8'h01 : (prev << 1);
                checks++;
                if (cnt != period || cur !== want) begin
                    fails++;
                    $display("FAIL period inst=%0d step=%0d interval=%0d want %0d col_sel=%h want %h",
                             inst, i, cnt, period, cur, want);
                end
                prev = cur;
            end
        end
    endtask

`ifdef LMD_SOUT_EN
    task automatic test_sout();
        logic first, second;
        reset = 1'b1;
        @(negedge dclk);
        reset = 1'b0;
        first  = $urandom_range(0, 1) != 0;
        second = !first;
        for (int i = 0; i < 129; i++) begin
            din       = (i == 0) ? first : (i == 1) ? second : ($urandom_range(0, 1) != 0);
            din_valid = 1'b1;
            @(negedge dclk);
            if (i == 127) begin
                checks++; if (sout !== first) begin fails++; $display("FAIL sout_128 got %b want %b", sout, first); end
            end
        end
        din_valid = 1'b0;
        checks++; if (sout !== second) begin fails++; $display("FAIL sout_129 got %b want %b", sout, second); end
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_pending();
        test_reset_mid();
        test_period();
`ifdef LMD_SOUT_EN
        test_sout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/led_matrix_pwm_driver.md
LED_MATRIX_PWM_DRIVER -- requirements
Module: led_matrix_pwm_driver

Interface
REQ-001 SHALL have parameter NCOLS, default 8: number of column drive lines.
REQ-002 SHALL have parameter NROWS, default 8: number of row data lines.
REQ-003 SHALL have parameter BPP, default 2: brightness bits per pixel, range 1..4.
REQ-004 SHALL have parameter PHASE_W, default 5: column-dwell phase counter width, PHASE_W > BPP.
REQ-005 SHALL have parameter PRESC, default 90: dclk cycles per phase tick, PRESC >= 1.
REQ-006 SHALL have port dclk, in, 1: the only clock; all logic on its rising edge.
REQ-007 SHALL have port reset, in, 1: synchronous, active-high reset.
REQ-008 SHALL have port din, in, 1: serial pixel data.
REQ-009 SHALL have port din_valid, in, 1: shift din into the chain this cycle.
REQ-010 SHALL have port din_ready, out, 1: high when a shift is accepted (= !pending).
REQ-011 SHALL have port strobe, in, 1: request frame-buffer update from the chain.
REQ-012 SHALL have port blank_len, in, PHASE_W: blanking phases at the start of each column dwell.
REQ-013 SHALL have port row_out, out, NROWS: row data for the active column.
REQ-014 SHALL have port col_sel, out, NCOLS: one-hot active column enable.
REQ-015 SHALL have port frame_ack, out, 1: one-cycle pulse on buffer swap.

Function
REQ-016 SHALL keep a shift chain of NCOLS*NROWS*BPP bits; shift in din at bit 0 when din_valid && din_ready, older bits moving to higher indices.
REQ-017 SHALL map pixel p = col*NROWS+row to chain/buffer bits [p*BPP +: BPP], MSB first on the wire.
REQ-018 SHALL set pending on strobe; a strobe while pending is ignored.
REQ-019 SHALL copy the chain into the frame buffer, clear pending and pulse frame_ack for one cycle on the tick where col wraps NCOLS-1 -> 0 and phase wraps to 0 (tear-free swap).
REQ-020 SHALL run a prescaler 0..PRESC-1; tick asserted on the cycle the count equals PRESC-1.
REQ-021 SHALL advance phase (PHASE_W bits, wraps) on each tick; on phase wrap, col advances modulo NCOLS.
REQ-022 SHALL drive col_sel one-hot at col, all-zero while phase < blank_len.
REQ-023 SHALL drive row_out[r] = 1 iff phase >= blank_len and (phase >> (PHASE_W-BPP)) < pixel value at (col, r); value 0 never lit.
REQ-024 SHALL register row_out and col_sel: one dclk latency from phase/col/buffer state.
REQ-025 SHALL treat blank_len = 0 as no blanking; blank_len >= 2^PHASE_W-1 leaves at most one lit phase per dwell.

Reset
REQ-026 SHALL clear chain, frame buffer, pending, prescaler, phase, col, row_out, col_sel, frame_ack on reset; din_ready reads 1.
REQ-027 SHALL, on reset mid-load or mid-pending, discard the pending request and partial chain contents.

Configuration
REQ-028 SHALL, with LMD_SOUT_EN defined, add output sout (1 bit) = chain MSB for daisy-chaining, reset 0; without it, no sout port and no extra logic.

Structure
REQ-029 SHALL place pixel-index/width helper constants and the phase-compare function in package led_matrix_pkg.
REQ-030 SHALL implement the prescaler/phase/column sequencing in sub-module lmd_scan_timer.

Verification
REQ-031 Reset, then shift 128 bits all ones, strobe -> frame_ack at next frame wrap; each column gets row_out=8'hFF for phases blank_len..23 with blank_len=4, zero for 24..31.
REQ-032 Pixel (col 2, row 5) = 2'b01, rest 0, blank_len=0 -> row_out=8'h20 only while col_sel=8'h04 and phase 0..7.
REQ-033 Strobe then din_valid while pending -> din_ready=0, chain unchanged, displayed frame equals pre-strobe chain.
REQ-034 PRESC=1 vs PRESC=90 -> column period 32 vs 2880 dclk cycles; col_sel sequence 01,02,...,80,01.
REQ-035 Assert reset while pending with shift in progress -> all outputs 0 next cycle, no frame_ack afterwards.
REQ-036 With LMD_SOUT_EN, shift 129 bits -> sout equals first bit shifted after 128 shifts.
